// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two packet sources: whole-packet round-robin
// grants, per-byte trmt/tx_done sequencing, and a watchdog that reclaims stalled grants.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_vld,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ack,
    input  logic       req1_vld,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ack,
    output logic [1:0] gnt,
    output logic       abort,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, HOLD} state_t;

    state_t        state;
    logic          owner;
    logic          ptr;
    logic          last_q;
    logic [7:0]    data_q;
    logic [CW-1:0] cnt;

    logic          pick;
    logic          sel;
    logic          sel_vld;
    logic          sel_last;
    logic [7:0]    sel_data;

    // With both pending the pointer decides; otherwise the lone requester wins.
    assign pick     = (req0_vld && req1_vld) ? ptr : req1_vld;
    assign sel      = (state == IDLE) ? pick : owner;
    assign sel_vld  = sel ? req1_vld  : req0_vld;
    assign sel_last = sel ? req1_last : req0_last;
    assign sel_data = sel ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            ptr      <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= 8'h00;
            cnt      <= '0;
            gnt      <= 2'b00;
            abort    <= 1'b0;
            trmt     <= 1'b0;
            tx_data  <= 8'h00;
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
        end else begin
            trmt     <= 1'b0;
            abort    <= 1'b0;
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_vld || req1_vld) begin
                        owner  <= pick;
                        gnt    <= pick ? 2'b10 : 2'b01;
                        data_q <= sel_data;
                        last_q <= sel_last;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    trmt    <= 1'b1;
                    tx_data <= data_q;
                    state   <= BUSY;
                end
                BUSY: begin
                    if (tx_done) begin
                        req0_ack <= ~owner;
                        req1_ack <= owner;
                        if (last_q) begin
                            gnt   <= 2'b00;
                            ptr   <= ~owner;
                            state <= IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A byte arriving in the final watchdog cycle still wins.
                    if (sel_vld) begin
                        data_q <= sel_data;
                        last_q <= sel_last;
                        state  <= LOAD;
                    end else if (cnt == CNT_LAST) begin
                        abort <= 1'b1;
                        gnt   <= 2'b00;
                        ptr   <= ~owner;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
